cf_shift_ctrl: RTL and testbench

Sequencer for the 128-bit byte-rotating state register in the WBC datapath. On a `start` request it loads the register from `ReC` or `ReF`, then issues a programmed number of fixed-size byte-rotate steps. Each step can be stalled by a downstream `hold`, and the job ends with a one-cycle `done`. It drives the register's `EN_R_1`/`sel_1` controls directly and owns no datapath bits itself.

---
 rtl/cf_shift_ctrl.sv | 114 +++++++++++
 tb/tb_cf_shift_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_shift_ctrl.sv
// Control sequencer for the WBC 128-bit byte-rotating state register: source load, N rotate steps, done pulse.
// Define CF_SHIFT_CTRL_OFS_EN to build the cumulative rotation-offset register behind rot_ofs.
module cf_shift_ctrl #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_sel,
  input  logic [1:0]        shift_amt,
  input  logic [STEP_W-1:0] n_steps,
  input  logic              hold,
  input  logic              abort,
  output logic              EN_R_1,
  output logic [2:0]        sel_1,
  output logic              busy,
  output logic              step_vld,
  output logic [STEP_W-1:0] step_cnt,
  output logic              done,
  output logic [3:0]        rot_ofs
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              src_q;
  logic [1:0]        amt_q;
  logic [STEP_W-1:0] n_q;
  logic [STEP_W-1:0] cnt_inc;
  logic              accept;

  assign accept  = (state == S_IDLE) && start;
  assign cnt_inc = step_cnt + 1'b1;

  // NOTE: every output and state_nxt gets a default before the case so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    EN_R_1    = 1'b0;
    sel_1     = 3'b000;
    busy      = 1'b1;
    step_vld  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        EN_R_1 = !abort;
        sel_1  = {2'b00, src_q};
        if (abort)            state_nxt = S_IDLE;
        else if (n_q != '0)   state_nxt = S_SHIFT;
        else                  state_nxt = S_DONE;
      end
      S_SHIFT: begin
        sel_1 = 3'b010 + {1'b0, amt_q};
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (!hold) begin
          EN_R_1   = 1'b1;
          step_vld = 1'b1;
          if (cnt_inc == n_q) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = !abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      src_q    <= 1'b0;
      amt_q    <= 2'b00;
      n_q      <= '0;
      step_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_q    <= src_sel;
        amt_q    <= shift_amt;
        n_q      <= n_steps;
        step_cnt <= '0;
      end else if (step_vld) begin
        step_cnt <= cnt_inc;
      end
    end
  end

`ifdef CF_SHIFT_CTRL_OFS_EN
  // Offset tracks the byte rotation the datapath has actually committed since the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_ofs <= 4'd0;
    end else if (accept) begin
      rot_ofs <= 4'd0;
    end else if (step_vld) begin
      rot_ofs <= rot_ofs + {2'b00, amt_q} + 4'd1;
    end
  end
`else
  assign rot_ofs = 4'd0;
`endif

endmodule

// File: tb/tb_cf_shift_ctrl.sv
// Self-checking bench for cf_shift_ctrl: directed vector table, async-reset sequence, then random
// stimulus against a job-level reference model.
module tb_cf_shift_ctrl;

  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              src_sel;
  logic [1:0]        shift_amt;
  logic [STEP_W-1:0] n_steps;
  logic              hold;
  logic              abort;
  logic              EN_R_1;
  logic [2:0]        sel_1;
  logic              busy;
  logic              step_vld;
  logic [STEP_W-1:0] step_cnt;
  logic              done;
  logic [3:0]        rot_ofs;

  cf_shift_ctrl #(.STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_sel(src_sel), .shift_amt(shift_amt),
    .n_steps(n_steps), .hold(hold), .abort(abort), .EN_R_1(EN_R_1), .sel_1(sel_1),
    .busy(busy), .step_vld(step_vld), .step_cnt(step_cnt), .done(done), .rot_ofs(rot_ofs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected rot_ofs value depends on whether the offset feature is built.
  function automatic logic [3:0] ofs_x(input int v);
`ifdef CF_SHIFT_CTRL_OFS_EN
    return 4'(v % 16);
`else
    return 4'(v * 0);
`endif
  endfunction

  task automatic check_outs(input string tag, input logic en, input logic [2:0] sel, input logic cs,
                            input logic vld, input logic dn, input logic bz,
                            input logic [3:0] cnt, input logic [3:0] ofs);
    check({tag, " EN_R_1"},   32'(EN_R_1),   32'(en));
    if (cs) check({tag, " sel_1"}, 32'(sel_1), 32'(sel));
    check({tag, " step_vld"}, 32'(step_vld), 32'(vld));
    check({tag, " done"},     32'(done),     32'(dn));
    check({tag, " busy"},     32'(busy),     32'(bz));
    check({tag, " step_cnt"}, 32'(step_cnt), 32'(cnt));
    check({tag, " rot_ofs"},  32'(rot_ofs),  32'(ofs));
  endtask

  typedef struct {
    logic       start, src;
    logic [1:0] amt;
    logic [3:0] n;
    logic       hold, abort;
    logic       en;
    logic [2:0] sel;
    logic       chk_sel;
    logic       vld, done, busy;
    logic [3:0] cnt, ofs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int st, input int src, input int amt, input int n, input int hd,
                              input int ab, input int en, input int sel, input int cs, input int vld,
                              input int dn, input int bz, input int cnt, input int ofs);
    vec_t v;
    v.start = 1'(st);  v.src = 1'(src); v.amt = 2'(amt); v.n = 4'(n);
    v.hold  = 1'(hd);  v.abort = 1'(ab);
    v.en    = 1'(en);  v.sel = 3'(sel); v.chk_sel = 1'(cs);
    v.vld   = 1'(vld); v.done = 1'(dn); v.busy = 1'(bz);
    v.cnt   = 4'(cnt); v.ofs = ofs_x(ofs);
    return v;
  endfunction

  // Job-level reference model: progress of the current job, not a copy of the RTL state machine.
  bit m_active, m_loaded, m_final, m_src;
  int m_amt, m_n, m_cnt, m_ofs;

  task automatic model_reset();
    m_active = 0; m_loaded = 0; m_final = 0; m_src = 0;
    m_amt = 0; m_n = 0; m_cnt = 0; m_ofs = 0;
  endtask

  task automatic model_edge();
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_loaded = 0; m_final = 0;
        m_src = src_sel; m_amt = int'(shift_amt); m_n = int'(n_steps);
        m_cnt = 0; m_ofs = 0;
      end
    end else if (abort) begin
      m_active = 0;
    end else if (!m_loaded) begin
      m_loaded = 1;
      if (m_n == 0) m_final = 1;
    end else if (m_final) begin
      m_active = 0;
    end else if (!hold) begin
      m_cnt++;
      m_ofs = (m_ofs + m_amt + 1) % 16;
      if (m_cnt == m_n) m_final = 1;
    end
  endtask

  task automatic model_compare(input int cyc);
    logic en, vld, dn, bz, cs;
    logic [2:0] sel;
    string tag;
    en = 0; vld = 0; dn = 0; bz = 0; cs = 1; sel = 3'b000;
    if (m_active) begin
      bz = 1;
      if (!m_loaded) begin
        en  = !abort;
        sel = {2'b00, m_src};
      end else if (m_final) begin
        dn = !abort;
        cs = 0;
      end else begin
        sel = 3'(2 + m_amt);
        en  = !hold && !abort;
        vld = en;
      end
    end
    tag = $sformatf("rnd%0d", cyc);
    check_outs(tag, en, sel, cs, vld, dn, bz, 4'(m_cnt), ofs_x(m_ofs));
  endtask

  initial begin
    rst = 1'b1; start = 0; src_sel = 0; shift_amt = 0; n_steps = 0; hold = 0; abort = 0;

    // Reset, then ten idle cycles with start low.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 3'b000, 1, 0, 0, 0, 4'd0, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d EN_R_1", i), 32'(EN_R_1), 32'd0);
      check($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end

    //          st src amt n hd ab | en sel cs vld dn bz cnt ofs
    // src=1 amt=1 n=3, hold during LOAD is ignored
    tbl.push_back(mk(1, 1, 1, 3, 0, 0,  0, 0, 1, 0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 3, 1, 1, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 3, 1, 1, 0, 1,  1,  2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 3, 1, 1, 0, 1,  2,  4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  3,  6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  3,  6));
    // amt=3 n=4 with hold in cycles 3 and 4; offset wraps to 0
    tbl.push_back(mk(1, 0, 3, 4, 0, 0,  0, 0, 1, 0, 0, 0,  3,  6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 5, 1, 1, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 5, 1, 0, 0, 1,  1,  4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 5, 1, 0, 0, 1,  1,  4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 5, 1, 1, 0, 1,  1,  4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 5, 1, 1, 0, 1,  2,  8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 5, 1, 1, 0, 1,  3, 12));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  4,  0));
    // n=0 src=0 accepted in the first IDLE cycle after DONE; abort in IDLE does nothing
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  4,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0,  0,  0));
    // n=5 aborted in its second SHIFT cycle, immediate restart, starts during SHIFT/DONE ignored
    tbl.push_back(mk(1, 1, 0, 5, 0, 0,  0, 0, 1, 0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2, 1, 1, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 2, 1, 0, 0, 1,  1,  1));
    tbl.push_back(mk(1, 1, 2, 2, 0, 0,  0, 0, 1, 0, 0, 0,  1,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 4, 1, 1, 0, 1,  0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 4, 1, 1, 0, 1,  1,  3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  2,  6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  2,  6));
    // start and abort together in IDLE starts the job
    tbl.push_back(mk(1, 0, 1, 1, 0, 1,  0, 0, 1, 0, 0, 0,  2,  6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 3, 1, 1, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  1,  2));
    // abort during LOAD
    tbl.push_back(mk(1, 1, 0, 2, 0, 0,  0, 0, 1, 0, 0, 0,  1,  2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0,  0));

    foreach (tbl[i]) begin
      start = tbl[i].start; src_sel = tbl[i].src; shift_amt = tbl[i].amt;
      n_steps = tbl[i].n; hold = tbl[i].hold; abort = tbl[i].abort;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].en, tbl[i].sel, tbl[i].chk_sel, tbl[i].vld,
                 tbl[i].done, tbl[i].busy, tbl[i].cnt, tbl[i].ofs);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a SHIFT phase.
    start = 1; src_sel = 0; shift_amt = 2; n_steps = 5; hold = 0; abort = 0;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-rst step_vld", 32'(step_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_outs("async-rst", 0, 3'b000, 1, 0, 0, 0, 4'd0, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Random stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 2) == 0);
      src_sel   = 1'($urandom_range(0, 1));
      shift_amt = 2'($urandom_range(0, 3));
      n_steps   = 4'($urandom_range(0, 15));
      hold      = ($urandom_range(0, 2) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      model_compare(c);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
